time_to_posix_time: RTL
=======================

TIME_TO_POSIX_TIME -- requirements
Module: time_to_posix_time

Interface
REQ-001 The block SHALL have parameter GMT, default 3, meaning the local-time offset from UTC in whole hours (signed, -12..14).
REQ-002 Port clk_i, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_i, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-004 Port posix_time_i, input, 32 bits, SHALL carry the current running POSIX time (UTC seconds).
REQ-005 Ports hour_i (5 bits), min_i (6 bits) and sec_i (6 bits), all inputs, SHALL carry the requested local wall-clock time.
REQ-006 Port req_i, input, 1 bit, SHALL be the set request, sampled only while idle.
REQ-007 Port busy_o, output, 1 bit, SHALL flag that a conversion is in progress.
REQ-008 Port user_posix_time_o, output, 32 bits, SHALL carry the computed POSIX time for loading the running counter.
REQ-009 Port user_posix_time_en_o, output, 1 bit, SHALL be the one-clock load strobe for user_posix_time_o.
REQ-010 Port err_o, output, 1 bit, SHALL be the one-clock reject strobe.

Function
REQ-011 The FSM SHALL have four states: IDLE, DIV, SUM, OUT.
REQ-012 IDLE with req_i=1 (accept edge) SHALL:
- capture hour_i/min_i/sec_i;
- load local = posix_time_i + GMT*3600, computed mod 2^32;
- go to DIV.
REQ-013 DIV SHALL compute rem = local mod 86400 by 32-cycle restoring shift-subtract, one quotient bit per clock, then go to SUM.
REQ-014 SUM SHALL compute, in one clock and mod 2^32:
- day_start = local - rem;
- result = day_start + hour*3600 + min*60 + sec - GMT*3600;
- constant multiplies SHALL be implemented as shift-add.
REQ-015 OUT SHALL drive user_posix_time_en_o=1 for exactly one clock, then return to IDLE.
REQ-016 The en_o pulse SHALL occur in the 34th clock after the accept edge.
REQ-017 busy_o SHALL be 1 from the clock after the accept edge through the OUT clock inclusive.
REQ-018 req_i asserted while busy_o=1 SHALL be ignored and SHALL NOT be queued.
REQ-019 req_i asserted in the clock after OUT SHALL be accepted normally (back-to-back).
REQ-020 user_posix_time_o SHALL hold its last value between strobes.
REQ-021 Changes on posix_time_i or on hour_i/min_i/sec_i after the accept edge SHALL NOT affect the current result.
REQ-022 32-bit overflow or underflow of local or result SHALL wrap mod 2^32 without flagging.

Reset
REQ-023 rst_i=1 SHALL immediately force:
- state=IDLE;
- busy_o=0, user_posix_time_en_o=0, err_o=0;
- user_posix_time_o=0.
REQ-024 Reset mid-conversion SHALL abort it with no strobe.
REQ-025 After reset release the first accepted req_i SHALL behave as from power-up.

Configuration
REQ-026 With macro TIME_SET_RANGE_CHECK_EN defined, an accept with hour_i>23, min_i>59 or sec_i>59 SHALL:
- produce err_o=1 for one clock on the clock after the accept edge;
- leave state in IDLE;
- produce no user_posix_time_en_o;
- leave busy_o at 0.
REQ-027 Without TIME_SET_RANGE_CHECK_EN:
- err_o SHALL be tied 0;
- out-of-range fields SHALL be used arithmetically as given.

Structure
REQ-028 Package posix_time_pkg SHALL hold:
- SEC_PER_MIN=60, SEC_PER_HOUR=3600, SEC_PER_DAY=86400;
- the FSM state enum;
- field width constants (5/6/6).
REQ-029 The restoring remainder unit SHALL be sub-module posix_mod_day, with start/done handshake, 32-bit dividend, 17-bit remainder and a fixed 32-cycle latency.

Verification
REQ-030 GMT=3, posix_time_i=0, set 12:00:00 -> 34 clocks later en_o=1, user_posix_time_o=32400.
REQ-031 GMT=3, posix_time_i=1700000000, set 00:00:00 -> user_posix_time_o=1699995600.
REQ-032 Second req_i pulsed at accept+10 -> ignored; exactly one strobe at accept+34.
REQ-033 rst_i pulsed at accept+20 -> no en_o; busy_o=0 immediately; the next request completes 34 clocks after its accept edge.
REQ-034 TIME_SET_RANGE_CHECK_EN defined, set 24:00:00 -> err_o at accept+1, no en_o, busy_o stays 0.
REQ-035 Without TIME_SET_RANGE_CHECK_EN, set 24:00:00, GMT=0, posix_time_i=0 -> user_posix_time_o=86400, err_o stays 0.

Source files
------------

// File: rtl/posix_time_pkg.sv
// posix_time_pkg: time constants, field widths and FSM state type for the wall-clock setter
package posix_time_pkg;
  localparam int SEC_PER_MIN  = 60;
  localparam int SEC_PER_HOUR = 3600;
  localparam int SEC_PER_DAY  = 86400;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  typedef enum logic [1:0] {IDLE, DIV, SUM, OUT} state_t;
endpackage

// File: rtl/posix_mod_day.sv
// posix_mod_day: restoring shift-subtract remainder of a 32-bit value by one day, 32 clocks start to done
module posix_mod_day
  import posix_time_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  output logic        done_o,
  output logic [16:0] rem_o
);
  logic [31:0] sh;
  logic [4:0]  cnt;
  logic        run;
  function automatic logic [16:0] step(input logic [16:0] r, input logic b);
    logic [17:0] t;
    t = {r, b};
    return (t >= 18'(SEC_PER_DAY)) ? 17'(t - 18'(SEC_PER_DAY)) : t[16:0];
  endfunction
  // first quotient bit is resolved on the start edge itself
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sh     <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done_o <= 1'b0;
      rem_o  <= '0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        rem_o <= step(17'd0, dividend_i[31]);
        sh    <= {dividend_i[30:0], 1'b0};
        cnt   <= 5'd1;
        run   <= 1'b1;
      end else if (run) begin
        rem_o <= step(rem_o, sh[31]);
        sh    <= {sh[30:0], 1'b0};
        cnt   <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          run    <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/time_to_posix_time.sv
// time_to_posix_time: turns a requested local wall-clock time into a POSIX load value for today.
// Define TIME_SET_RANGE_CHECK_EN to reject out-of-range hour/min/sec with err_o.
module time_to_posix_time
  import posix_time_pkg::*;
#(
  parameter int GMT = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       posix_time_i,
  input  logic [HOUR_W-1:0] hour_i,
  input  logic [MIN_W-1:0]  min_i,
  input  logic [SEC_W-1:0]  sec_i,
  input  logic              req_i,
  output logic              busy_o,
  output logic [31:0]       user_posix_time_o,
  output logic              user_posix_time_en_o,
  output logic              err_o
);
  localparam logic [31:0] GMT_OFS = 32'(GMT * SEC_PER_HOUR);
  state_t            state;
  logic [31:0]       loc_time, local_in, hour_x, min_x, result;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  min;
  logic [SEC_W-1:0]  sec;
  logic [16:0]       rem;
  logic              done, accept, bad, start;
`ifdef TIME_SET_RANGE_CHECK_EN
  assign bad = hour_i > 5'd23 || min_i > 6'd59 || sec_i > 6'd59;
`else
  assign bad = 1'b0;
`endif
  assign accept   = state == IDLE && req_i;
  assign start    = accept && !bad;
  assign local_in = posix_time_i + GMT_OFS;
  // 3600 = 2048+1024+512+16, 60 = 64-4
  assign hour_x = ({27'd0, hour} << 11) + ({27'd0, hour} << 10) + ({27'd0, hour} << 9) + ({27'd0, hour} << 4);
  assign min_x  = ({26'd0, min} << 6) - ({26'd0, min} << 2);
  assign result = loc_time - {15'd0, rem} + hour_x + min_x + {26'd0, sec} - GMT_OFS;
  posix_mod_day u_mod (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start),
    .dividend_i (local_in),
    .done_o     (done),
    .rem_o      (rem)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state                <= IDLE;
      busy_o               <= 1'b0;
      user_posix_time_en_o <= 1'b0;
      err_o                <= 1'b0;
      user_posix_time_o    <= '0;
      loc_time             <= '0;
      hour                 <= '0;
      min                  <= '0;
      sec                  <= '0;
    end else begin
      user_posix_time_en_o <= 1'b0;
      err_o                <= accept && bad;
      case (state)
        IDLE: if (start) begin
          loc_time <= local_in;
          hour     <= hour_i;
          min      <= min_i;
          sec      <= sec_i;
          busy_o   <= 1'b1;
          state    <= DIV;
        end
        DIV: if (done) state <= SUM;
        SUM: begin
          user_posix_time_o    <= result;
          user_posix_time_en_o <= 1'b1;
          state                <= OUT;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
endmodule
